rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
Shares the register file's single write port (A3/WE3/D3) between the in-order pipeline writeback stage and a long-latency unit such as a divider or memory miss path. It also keeps a per-register scoreboard of destinations owned by the long-latency unit, so issue can detect RAW and WAW hazards. The block sits between the writeback sources and RegisterFile.

Parameters:
XLEN, 32, data width
NREG, 32, architectural register count; register 0 is hardwired zero
MAX_WAIT, 4, consecutive lost arbitrations after which the long-latency unit is forced to win (at least 1)

Ports:
clk  in  1  clock, rising edge; RegisterFile writes on the falling edge
rst_n  in  1  asynchronous active-low reset
p_valid  in  1  pipeline writeback request
p_rd  in  5  pipeline destination register
p_data  in  XLEN  pipeline write data
p_ready  out  1  pipeline request accepted this cycle
l_valid  in  1  long-latency unit writeback request
l_rd  in  5  long-latency destination register
l_data  in  XLEN  long-latency write data
l_ready  out  1  long-latency request accepted this cycle
alloc_valid  in  1  issue is claiming l-unit ownership of alloc_rd
alloc_rd  in  5  register being claimed
alloc_stall  out  1  claim refused because alloc_rd is already pending
q_rs1, q_rs2  in  5 each  hazard query addresses
q_busy1, q_busy2  out  1 each  queried register is pending
pending  out  NREG  scoreboard vector
wb_we  out  1  to RegisterFile WE3
wb_addr  out  5  to RegisterFile A3
wb_data  out  XLEN  to RegisterFile D3
sb_err  out  1  sticky scoreboard protocol violation

Behaviour:
- Reset (asynchronous, rst_n=0): pending=0, wait_cnt=0, wb_we=0, wb_addr=0, wb_data=0, sb_err=0. Any in-flight write is dropped. Outputs return to these values immediately, without waiting for a clock edge.
- Arbitration is combinational from the current inputs and wait_cnt:
  - starve = (wait_cnt == MAX_WAIT).
  - p_ready = !(l_valid && starve).
  - l_ready = l_valid && (!p_valid || starve).
  - Ready may depend on valid; requesters must not make valid depend on ready.
- Transfer: a request transfers when valid && ready. At most one transfer occurs per cycle.
- wait_cnt: increments (saturating at MAX_WAIT) when l_valid && !l_ready. Clears when an l transfer occurs or when l_valid=0.
- Write output (registered, latency 1):
  - A transfer at rising edge T drives wb_we=1, wb_addr=rd, wb_data=data during cycle T+1. RegisterFile commits at the falling edge inside T+1.
  - With no transfer, wb_we=0 and wb_addr/wb_data hold their previous values.
  - A transfer with rd=0 is accepted but produces wb_we=0.
- Scoreboard:
  - Set: on alloc_valid && alloc_rd!=0 && !pending[alloc_rd], set pending[alloc_rd] at the next edge.
  - Refuse: alloc_stall = alloc_valid && alloc_rd!=0 && pending[alloc_rd] (combinational). A refused claim has no effect, and issue retries.
  - Clear: an l transfer clears pending[l_rd] at the same edge that launches the write.
  - Same-cycle claim and clear of the same register: the clear wins and the claim is stalled, because pending is still 1 during that cycle.
  - Claim of one register alongside clear of a different register: both take effect.
  - Ordering guarantee: pending clears at edge T, so reads of RegisterFile after the falling edge in T+1 return the new value. Issue must sample regfile data only after q_busy has been low for one full cycle.
- q_busyN = (q_rsN != 0) && pending[q_rsN], computed from registered state only (no bypass).
- sb_err is set and held until reset on either violation:
  - an l transfer whose l_rd!=0 has pending[l_rd]=0 (the write still occurs);
  - a p transfer whose p_rd!=0 has pending[p_rd]=1 (WAW).

Decomposition:
- Shared package rf_pkg: XLEN, REG_AW=5, NREG, ZERO_REG=0, requester ids SRC_PIPE=0 and SRC_LONG=1.
- One sub-module, rf_scoreboard, holds the pending vector, set/clear logic, alloc_stall, both query ports and the sb_err checks.
- The top level holds arbitration, wait_cnt and the write-output register.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle while wb_we=1 -> wb_we, wb_addr, wb_data, pending and sb_err read 0 before the next edge.
2. Pipeline only: p_valid, p_rd=5, p_data=0xDEADBEEF -> p_ready=1; next cycle wb_we=1, wb_addr=5, wb_data=0xDEADBEEF; RegisterFile x5 holds 0xDEADBEEF after the falling edge.
3. Contention with MAX_WAIT=4, p_valid and l_valid held high -> p wins cycles 0-3; cycle 4 has p_ready=0 and l_ready=1; wait_cnt returns to 0; pattern repeats.
4. Scoreboard:
   - claim rd=7 -> pending[7]=1; q_rs1=7 gives q_busy1=1;
   - claim rd=7 again -> alloc_stall=1;
   - l write rd=7 with data 0x12 -> pending[7]=0 next cycle and wb_data=0x12.
5. x0 handling: p write rd=0 data 0xFFFFFFFF -> p_ready=1, wb_we stays 0; claim rd=0 -> pending stays 0, alloc_stall=0.
6. Violation: l write rd=9 with pending[9]=0 -> write performed and sb_err=1, held through later traffic until rst_n=0.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, register ids and requester ids for the writeback arbiter
package rf_pkg;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int NREG = 32;
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef enum logic {
        SRC_PIPE = 1'b0,
        SRC_LONG = 1'b1
    } src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-destination scoreboard for long-latency writebacks
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG_P = rf_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_alloc_valid,
    input  logic [REG_AW-1:0] i_alloc_rd,
    input  logic              i_l_xfer,
    input  logic [REG_AW-1:0] i_l_rd,
    input  logic              i_p_xfer,
    input  logic [REG_AW-1:0] i_p_rd,
    input  logic [REG_AW-1:0] i_q_rs1,
    input  logic [REG_AW-1:0] i_q_rs2,
    output logic              o_alloc_stall,
    output logic              o_q_busy1,
    output logic              o_q_busy2,
    output logic [NREG_P-1:0] o_pending,
    output logic              o_sb_err
);
    logic [NREG_P-1:0] r_pending;
    logic              r_sb_err;
    logic [NREG_P-1:0] w_pending_nxt;
    logic              w_set;
    logic              w_clr;
    logic              w_l_err;
    logic              w_p_err;

    assign w_set   = i_alloc_valid && (i_alloc_rd != ZERO_REG) && !r_pending[i_alloc_rd];
    assign w_clr   = i_l_xfer && (i_l_rd != ZERO_REG);
    assign w_l_err = i_l_xfer && (i_l_rd != ZERO_REG) && !r_pending[i_l_rd];
    assign w_p_err = i_p_xfer && (i_p_rd != ZERO_REG) && r_pending[i_p_rd];

    // Clear is applied last so a same-register claim/clear leaves the entry free.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_set) w_pending_nxt[i_alloc_rd] = 1'b1;
        if (w_clr) w_pending_nxt[i_l_rd] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_sb_err  <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_l_err || w_p_err) r_sb_err <= 1'b1;
        end
    end

    assign o_alloc_stall = i_alloc_valid && (i_alloc_rd != ZERO_REG) && r_pending[i_alloc_rd];
    assign o_q_busy1     = (i_q_rs1 != ZERO_REG) && r_pending[i_q_rs1];
    assign o_q_busy2     = (i_q_rs2 != ZERO_REG) && r_pending[i_q_rs2];
    assign o_pending     = r_pending;
    assign o_sb_err      = r_sb_err;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - shares the register file write port between pipeline and long-latency unit
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN_P   = rf_pkg::XLEN,
    parameter int NREG_P   = rf_pkg::NREG,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_valid,
    input  logic [REG_AW-1:0] p_rd,
    input  logic [XLEN_P-1:0] p_data,
    output logic              p_ready,
    input  logic              l_valid,
    input  logic [REG_AW-1:0] l_rd,
    input  logic [XLEN_P-1:0] l_data,
    output logic              l_ready,
    input  logic              alloc_valid,
    input  logic [REG_AW-1:0] alloc_rd,
    output logic              alloc_stall,
    input  logic [REG_AW-1:0] q_rs1,
    input  logic [REG_AW-1:0] q_rs2,
    output logic              q_busy1,
    output logic              q_busy2,
    output logic [NREG_P-1:0] pending,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [XLEN_P-1:0] wb_data,
    output logic              sb_err
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0]     r_wait_cnt;
    logic              r_wb_we;
    logic [REG_AW-1:0] r_wb_addr;
    logic [XLEN_P-1:0] r_wb_data;
    logic              w_starve;
    logic              w_p_xfer;
    logic              w_l_xfer;
    logic              w_xfer;
    src_e              w_src;
    logic [REG_AW-1:0] w_rd;
    logic [XLEN_P-1:0] w_data;

    // Pipeline has priority until the long-latency unit has lost MAX_WAIT times in a row.
    assign w_starve = (r_wait_cnt == WW'(MAX_WAIT));
    assign p_ready  = !(l_valid && w_starve);
    assign l_ready  = l_valid && (!p_valid || w_starve);
    assign w_p_xfer = p_valid && p_ready;
    assign w_l_xfer = l_valid && l_ready;
    assign w_xfer   = w_p_xfer || w_l_xfer;
    assign w_src    = w_l_xfer ? SRC_LONG : SRC_PIPE;
    assign w_rd     = (w_src == SRC_LONG) ? l_rd : p_rd;
    assign w_data   = (w_src == SRC_LONG) ? l_data : p_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_wb_we    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            if (l_valid && !l_ready) begin
                if (!w_starve) r_wait_cnt <= r_wait_cnt + WW'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            r_wb_we <= w_xfer && (w_rd != ZERO_REG);
            if (w_xfer) begin
                r_wb_addr <= w_rd;
                r_wb_data <= w_data;
            end
        end
    end

    rf_scoreboard #(.NREG_P(NREG_P)) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_alloc_valid (alloc_valid),
        .i_alloc_rd    (alloc_rd),
        .i_l_xfer      (w_l_xfer),
        .i_l_rd        (l_rd),
        .i_p_xfer      (w_p_xfer),
        .i_p_rd        (p_rd),
        .i_q_rs1       (q_rs1),
        .i_q_rs2       (q_rs2),
        .o_alloc_stall (alloc_stall),
        .o_q_busy1     (q_busy1),
        .o_q_busy2     (q_busy2),
        .o_pending     (pending),
        .o_sb_err      (sb_err)
    );

    assign wb_we   = r_wb_we;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;
endmodule
